program_run_sequencer: RTL and testbench

//  Sequences the single-cycle MIPS datapath for one program run at a time. Accepts a run request
//  (start PC plus cycle budget), holds the core in PC-load, releases it, detects halt (self-jump:
//  PC stuck) or budget expiry, then captures the datapath result. Sits between the run requester
//  (bench/host) and the core's rst/inicioPC/PC/Saida nets. Replaces hand-timed rst sequencing.

---
 rtl/program_run_sequencer.sv | 150 +++++++++++++++
 tb/tb_program_run_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/program_run_sequencer.sv
// Run sequencer for the single-cycle MIPS datapath: holds the core in PC-load,
// releases it, detects halt (PC stuck) or budget expiry and captures the result.
module program_run_sequencer #(
  parameter int unsigned W            = 32,
  parameter int unsigned CYC_W        = 16,
  parameter int unsigned LOAD_CYCLES  = 2,
  parameter int unsigned STALL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_pc,
  input  logic [CYC_W-1:0] req_budget,
  output logic             core_rst,
  output logic [W-1:0]     core_pc_init,
  input  logic [W-1:0]     core_pc,
  input  logic [W-1:0]     core_result,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [W-1:0]     done_result,
  output logic             done_timeout,
  output logic [CYC_W-1:0] done_cycles,
  output logic             busy
);

  localparam int unsigned LOAD_W  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state, state_n;
  logic [LOAD_W-1:0]  load_cnt, load_cnt_n;
  logic [CYC_W-1:0]   cnt, cnt_n;
  logic [CYC_W-1:0]   budget_q, budget_n;
  logic [STALL_W-1:0] stall, stall_n;
  logic [W-1:0]       pc_q, pc_q_n;
  logic               req_ready_n, core_rst_n, done_valid_n, done_timeout_n, busy_n;
  logic [W-1:0]       core_pc_init_n, done_result_n;
  logic [CYC_W-1:0]   done_cycles_n;

  logic [CYC_W-1:0]   cnt_inc;
  logic [STALL_W-1:0] stall_upd;
  logic               halt, timeout;

  // Halt detection: first RUN edge has no previous PC to compare against
  always_comb begin
    cnt_inc   = cnt + CYC_W'(1);
    stall_upd = '0;
    if (cnt != '0 && core_pc == pc_q) stall_upd = stall + STALL_W'(1);
    halt      = (stall_upd == STALL_W'(STALL_CYCLES));
    timeout   = (cnt_inc == budget_q);
  end

  always_comb begin
    state_n        = state;
    load_cnt_n     = load_cnt;
    cnt_n          = cnt;
    budget_n       = budget_q;
    stall_n        = stall;
    pc_q_n         = pc_q;
    core_rst_n     = core_rst;
    core_pc_init_n = core_pc_init;
    done_valid_n   = done_valid;
    done_result_n  = done_result;
    done_timeout_n = done_timeout;
    done_cycles_n  = done_cycles;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          core_pc_init_n = req_pc;
          budget_n       = (req_budget == '0) ? CYC_W'(1) : req_budget;
          load_cnt_n     = '0;
          state_n        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_cnt == LOAD_W'(LOAD_CYCLES - 1)) begin
          state_n    = S_RUN;
          core_rst_n = 1'b1;
          cnt_n      = '0;
          stall_n    = '0;
          pc_q_n     = core_pc_init;
        end else begin
          load_cnt_n = load_cnt + LOAD_W'(1);
        end
      end
      S_RUN: begin
        cnt_n   = cnt_inc;
        pc_q_n  = core_pc;
        stall_n = stall_upd;
        if (halt || timeout) begin
          done_result_n  = core_result;
          done_cycles_n  = cnt_inc;
          done_timeout_n = !halt;
          core_rst_n     = 1'b0;
          done_valid_n   = 1'b1;
          state_n        = S_DONE;
        end
      end
      S_DONE: begin
        if (done_ready) begin
          done_valid_n = 1'b0;
          state_n      = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    req_ready_n = (state_n == S_IDLE);
    busy_n      = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      load_cnt     <= '0;
      cnt          <= '0;
      budget_q     <= '0;
      stall        <= '0;
      pc_q         <= '0;
      req_ready    <= 1'b0;
      core_rst     <= 1'b0;
      core_pc_init <= '0;
      done_valid   <= 1'b0;
      done_result  <= '0;
      done_timeout <= 1'b0;
      done_cycles  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      load_cnt     <= load_cnt_n;
      cnt          <= cnt_n;
      budget_q     <= budget_n;
      stall        <= stall_n;
      pc_q         <= pc_q_n;
      req_ready    <= req_ready_n;
      core_rst     <= core_rst_n;
      core_pc_init <= core_pc_init_n;
      done_valid   <= done_valid_n;
      done_result  <= done_result_n;
      done_timeout <= done_timeout_n;
      done_cycles  <= done_cycles_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_program_run_sequencer.sv
// Bench for program_run_sequencer: directed run vectors plus reset and
// back-to-back sequences, with a small behavioural datapath for integration runs.
module tb_program_run_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic [15:0] req_budget;
  logic        core_rst;
  logic [31:0] core_pc_init;
  logic [31:0] core_pc;
  logic [31:0] core_result;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_result;
  logic        done_timeout;
  logic [15:0] done_cycles;
  logic        busy;

  logic        use_model;
  logic [31:0] tb_pc, tb_result, m_pc, m_acc;

  int checks   = 0;
  int failures = 0;

  assign core_pc     = use_model ? m_pc  : tb_pc;
  assign core_result = use_model ? m_acc : tb_result;

  program_run_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_budget(req_budget),
    .core_rst(core_rst), .core_pc_init(core_pc_init), .core_pc(core_pc), .core_result(core_result),
    .done_valid(done_valid), .done_ready(done_ready), .done_result(done_result),
    .done_timeout(done_timeout), .done_cycles(done_cycles), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy datapath: sums PCs it steps through; programs self-jump at PC 16 and PC 72
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc  <= '0;
      m_acc <= '0;
    end else if (!core_rst) begin
      m_pc  <= core_pc_init;
      m_acc <= '0;
    end else if (m_pc != 32'd16 && m_pc != 32'd72) begin
      m_pc  <= m_pc + 32'd4;
      m_acc <= m_acc + m_pc;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [15:0] budget;
    int          mode;      // 0: PC 0,4,8,12,12..  1: PC +4 each edge  2: toy datapath
    logic [31:0] exp_result;
    logic [15:0] exp_cycles;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int k;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
    use_model  = (v.mode == 2);
    req_valid  = 1'b1;
    req_pc     = v.pc;
    req_budget = v.budget;
    tick();
    req_valid = 1'b0;
    chk($sformatf("v%0d_pc_init", idx), core_pc_init, v.pc);
    n = 0;
    while (!core_rst && n < 10) begin tick(); n++; end
    chk($sformatf("v%0d_load_len", idx), 32'(n), 32'd2);
    k = 0;
    while (!done_valid && k < 200) begin
      tb_pc     = (v.mode == 0) ? ((k < 3) ? 32'(4 * k) : 32'd12) : 32'(4 * k);
      tb_result = 32'(1000 + k);
      tick();
      k++;
    end
    chk($sformatf("v%0d_done_valid", idx), 32'(done_valid), 32'd1);
    chk($sformatf("v%0d_cycles", idx), 32'(done_cycles), 32'(v.exp_cycles));
    chk($sformatf("v%0d_timeout", idx), 32'(done_timeout), 32'(v.exp_to));
    chk($sformatf("v%0d_result", idx), done_result, v.exp_result);
    chk($sformatf("v%0d_core_rst_done", idx), 32'(core_rst), 32'd0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk($sformatf("v%0d_ack", idx), 32'(done_valid), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{pc: 32'd0,  budget: 16'd100, mode: 0, exp_result: 32'd1005, exp_cycles: 16'd6, exp_to: 1'b0};
    vecs[1] = '{pc: 32'd0,  budget: 16'd3,   mode: 1, exp_result: 32'd1002, exp_cycles: 16'd3, exp_to: 1'b1};
    vecs[2] = '{pc: 32'd0,  budget: 16'd6,   mode: 0, exp_result: 32'd1005, exp_cycles: 16'd6, exp_to: 1'b0};
    vecs[3] = '{pc: 32'd0,  budget: 16'd0,   mode: 1, exp_result: 32'd1000, exp_cycles: 16'd1, exp_to: 1'b1};
    vecs[4] = '{pc: 32'd0,  budget: 16'd5,   mode: 0, exp_result: 32'd1004, exp_cycles: 16'd5, exp_to: 1'b1};
    vecs[5] = '{pc: 32'd0,  budget: 16'd100, mode: 2, exp_result: 32'd24,   exp_cycles: 16'd7, exp_to: 1'b0};
    vecs[6] = '{pc: 32'd56, budget: 16'd100, mode: 2, exp_result: 32'd248,  exp_cycles: 16'd7, exp_to: 1'b0};
    vecs[7] = '{pc: 32'd56, budget: 16'd4,   mode: 2, exp_result: 32'd180,  exp_cycles: 16'd4, exp_to: 1'b1};

    rst = 1'b0; req_valid = 1'b0; req_pc = '0; req_budget = '0;
    done_ready = 1'b0; use_model = 1'b0; tb_pc = '0; tb_result = '0;
    #2;
    chk("rst_core_rst", 32'(core_rst), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_pc_init", core_pc_init, 32'd0);
    chk("rst_done_cycles", 32'(done_cycles), 32'd0);
    chk("rst_done_result", done_result, 32'd0);
    chk("rst_done_timeout", 32'(done_timeout), 32'd0);
    #10 rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Async reset mid-run
    while (!req_ready) tick();
    use_model = 1'b0; req_valid = 1'b1; req_pc = 32'd8; req_budget = 16'd100;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin tb_pc = 32'(4 * i); tick(); end
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_core_rst_before", 32'(core_rst), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_core_rst", 32'(core_rst), 32'd0);
    chk("mid_done_valid", 32'(done_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    tick();
    chk("mid_after_done_valid", 32'(done_valid), 32'd0);
    chk("mid_after_ready", 32'(req_ready), 32'd1);

    // Back-to-back: second request held valid through DONE
    use_model = 1'b1; req_valid = 1'b1; req_pc = 32'd0; req_budget = 16'd100;
    tick();
    req_pc = 32'd56;
    n = 0;
    while (!done_valid && n < 100) begin tick(); n++; end
    chk("b2b_first_done", 32'(done_valid), 32'd1);
    chk("b2b_first_result", done_result, 32'd24);
    chk("b2b_first_to", 32'(done_timeout), 32'd0);
    tick(); tick();
    chk("b2b_hold_valid", 32'(done_valid), 32'd1);
    chk("b2b_hold_ready", 32'(req_ready), 32'd0);
    chk("b2b_hold_pc_init", core_pc_init, 32'd0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("b2b_ack", 32'(done_valid), 32'd0);
    chk("b2b_not_yet", core_pc_init, 32'd0);
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_accept_pc", core_pc_init, 32'd56);
    chk("b2b_load0", 32'(core_rst), 32'd0);
    tick();
    chk("b2b_load1", 32'(core_rst), 32'd0);
    tick();
    chk("b2b_run", 32'(core_rst), 32'd1);
    n = 0;
    while (!done_valid && n < 100) begin tick(); n++; end
    chk("b2b_second_result", done_result, 32'd248);
    chk("b2b_second_to", 32'(done_timeout), 32'd0);
    chk("b2b_second_cycles", 32'(done_cycles), 32'd7);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
